// File: rtl/life_pkg.sv
// Shared sizing, key indices and cell addressing for the Game-of-Life LED array.
package life_pkg;

   localparam int ROWS  = 16;
   localparam int COLS  = 16;
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);

   typedef enum int unsigned {
      K_UP     = 0,
      K_DOWN   = 1,
      K_LEFT   = 2,
      K_RIGHT  = 3,
      K_TOGGLE = 4
   } key_e;

   localparam int NUM_KEYS = 5;

   // Row-major flat index of a cell; cols defaults to the array width.
   function automatic int cell_index(input int row, input int col, input int cols = COLS);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous board input with a one-cycle rising-edge pulse.
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse
);

   logic meta;
   logic stable;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta   <= 1'b0;
         stable <= 1'b0;
         prev   <= 1'b0;
      end else begin
         meta   <= raw;
         stable <= meta;
         prev   <= stable;
      end
   end

   assign level = stable;
   // A held key yields one pulse; prev must drop before another can fire.
   assign pulse = stable & ~prev;

endmodule

// File: rtl/cursor_controller.sv
// Cursor, cell-toggle and generation-tick control for the Game-of-Life pixel array.
module cursor_controller #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int TICK_DIV = 25000000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     key_up,
   input  logic                     key_down,
   input  logic                     key_left,
   input  logic                     key_right,
   input  logic                     key_toggle,
   input  logic                     setup,
   output logic [$clog2(ROWS)-1:0]  cursor_row,
   output logic [$clog2(COLS)-1:0]  cursor_col,
   output logic [ROWS*COLS-1:0]     selected,
   output logic                     toggle,
   output logic                     gen_step,
   output logic                     setup_sync
);
   import life_pkg::*;

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int SEL_W = $clog2(ROWS * COLS);
   localparam int CNT_W = $clog2(TICK_DIV);

   logic [NUM_KEYS-1:0] key_raw;
   logic [NUM_KEYS-1:0] unused_key_lvl;
   logic [NUM_KEYS-1:0] key_press;
   logic                unused_setup_rise;

   assign key_raw[K_UP]     = key_up;
   assign key_raw[K_DOWN]   = key_down;
   assign key_raw[K_LEFT]   = key_left;
   assign key_raw[K_RIGHT]  = key_right;
   assign key_raw[K_TOGGLE] = key_toggle;

   sync_edge u_key [NUM_KEYS-1:0] (
      .clk   (clk),
      .reset (reset),
      .raw   (key_raw),
      .level (unused_key_lvl),
      .pulse (key_press)
   );

   sync_edge u_setup (
      .clk   (clk),
      .reset (reset),
      .raw   (setup),
      .level (setup_sync),
      .pulse (unused_setup_rise)
   );

   // ---------------- cursor movement ----------------
   logic [RW-1:0] row_nxt;
   logic [CW-1:0] col_nxt;

   always_comb begin
      row_nxt = cursor_row;
      col_nxt = cursor_col;
      if (key_press[K_UP] && !key_press[K_DOWN])
         row_nxt = (cursor_row == '0) ? RW'(ROWS - 1) : cursor_row - RW'(1);
      else if (key_press[K_DOWN] && !key_press[K_UP])
         row_nxt = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
      if (key_press[K_LEFT] && !key_press[K_RIGHT])
         col_nxt = (cursor_col == '0) ? CW'(COLS - 1) : cursor_col - CW'(1);
      else if (key_press[K_RIGHT] && !key_press[K_LEFT])
         col_nxt = (cursor_col == CW'(COLS - 1)) ? '0 : cursor_col + CW'(1);
   end

   // A toggle press wins over moves so the flipped cell is the one on display.
   always_ff @(posedge clk) begin
      if (reset) begin
         cursor_row <= '0;
         cursor_col <= '0;
         toggle     <= 1'b0;
      end else begin
         toggle <= setup_sync & key_press[K_TOGGLE];
         if (setup_sync && !key_press[K_TOGGLE]) begin
            cursor_row <= row_nxt;
            cursor_col <= col_nxt;
         end
      end
   end

   // ---------------- cursor map ----------------
   logic [SEL_W-1:0] sel_idx;

   assign sel_idx = SEL_W'(cell_index(int'(cursor_row), int'(cursor_col), COLS));

   always_comb begin
      selected = '0;
      if (setup_sync)
         selected[sel_idx] = 1'b1;
   end

   // ---------------- generation tick ----------------
   logic [CNT_W-1:0] tick_cnt;

   always_ff @(posedge clk) begin
      if (reset || setup_sync) begin
         tick_cnt <= '0;
         gen_step <= 1'b0;
      end else if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         gen_step <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + CNT_W'(1);
         gen_step <= 1'b0;
      end
   end

endmodule

// File: doc/cursor_controller.md
Name: cursor_controller

Overview:
- Generates the per-cell `light_selected` and `toggle` inputs consumed by every Game-of-Life pixel cell in the LED array.
- Generates the generation-advance tick consumed by the array.
- Synchronises and edge-detects the user direction, toggle and setup controls.
- Sits between the board-level key/switch inputs and the pixel array; one instance per design.

Parameters:
- ROWS, 16, number of pixel rows in the array
- COLS, 16, number of pixel columns in the array
- TICK_DIV, 25000000, clock cycles per generation step in run mode (minimum 2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_up  input  1  raw up button, high = pressed, asynchronous to clk
- key_down  input  1  raw down button, high = pressed
- key_left  input  1  raw left button, high = pressed
- key_right  input  1  raw right button, high = pressed
- key_toggle  input  1  raw toggle button, high = pressed
- setup  input  1  raw setup switch, 1 = setup mode, 0 = run mode
- cursor_row  output  $clog2(ROWS)  current cursor row, 0 = top
- cursor_col  output  $clog2(COLS)  current cursor column, 0 = left
- selected  output  ROWS*COLS  one-hot cursor map, bit index row*COLS+col; drives each cell's light_selected and red pixel
- toggle  output  1  one-cycle pulse to flip the selected cell
- gen_step  output  1  one-cycle pulse to advance one generation
- setup_sync  output  1  synchronised setup level, fanned out to all cells

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - cursor_row = 0, cursor_col = 0
  - toggle = 0, gen_step = 0, setup_sync = 0
  - all synchroniser and edge-history flops = 0
  - tick counter = 0
- Synchronisation:
  - Every raw input passes through a 2-flop synchroniser.
  - setup_sync is the output of the second flop.
- Edge detect: press = sync2 & ~prev, where prev is sync2 delayed one cycle.
  - The press pulse is valid in the cycle after the second synchroniser edge.
  - A held key produces exactly one press. Release must be seen (prev = 0) before the next press.
- Setup mode (setup_sync = 1). On a clock edge where press pulses are valid:
  - press_toggle: toggle <= 1 for exactly one cycle. All direction presses in the same cycle are ignored (cursor unchanged), so the flipped cell is the one currently displayed.
  - press_up with !press_down: row decrements, wrapping 0 -> ROWS-1.
  - press_down with !press_up: row increments, wrapping ROWS-1 -> 0.
  - press_up and press_down together: row unchanged.
  - Left and right follow the same rules for the column, wrapping 0 <-> COLS-1. Row and column moves are independent and may occur in the same cycle.
- Run mode (setup_sync = 0):
  - Direction and toggle presses are discarded; cursor position is held.
  - toggle stays 0.
  - selected = all zeros, so no red pixel is shown.
- selected is combinational from the registered cursor and setup_sync. Exactly one bit is set in setup mode.
- Latency:
  - Raw key rising, sampled at edge k, gives the press pulse after edge k+1.
  - The cursor or toggle register updates at edge k+2.
  - selected reflects the new cursor in the same cycle that cursor_row/cursor_col change.
- Generation tick:
  - Counter 0..TICK_DIV-1, incrementing only while setup_sync = 0.
  - gen_step <= 1 on the edge where the counter wraps from TICK_DIV-1 to 0, so the period is exactly TICK_DIV cycles.
  - While setup_sync = 1 the counter is forced to 0 and gen_step = 0.
  - On leaving setup, the first gen_step occurs TICK_DIV cycles after setup_sync falls.
- Mode change: switching mode does not move the cursor. A press detected in the same cycle setup_sync falls is discarded.
- Reset mid-operation: all state returns to reset values on the next edge. Any partial press or tick in progress is lost, with no spurious pulse afterwards.

Decomposition:
- Package life_pkg:
  - ROWS, COLS, ROW_W = $clog2(ROWS), COL_W = $clog2(COLS)
  - key index enum { K_UP, K_DOWN, K_LEFT, K_RIGHT, K_TOGGLE }
  - function cell_index(row, col) = row*COLS + col
- Sub-module sync_edge:
  - 2-flop synchroniser plus rising-edge pulse, with outputs level and pulse.
  - Instantiated once per key and once for setup (level only used).

Test Plan (TICK_DIV = 4):
- Reset, setup = 1 held 3 cycles -> cursor (0,0); selected = only bit 0; toggle = 0; gen_step never asserts.
- setup = 1, key_up pulsed high 5 cycles, then key_left 5 cycles -> cursor (15,0), then (15,15); selected bit 255 only; each hold moves exactly once.
- setup = 1 at cursor (3,4), key_toggle and key_right rising in the same cycle -> toggle high exactly 1 cycle; cursor stays (3,4); selected bit 52.
- setup = 1, key_down and key_up rising together with key_right -> row unchanged, column +1.
- setup 1 -> 0 at cycle t -> selected = 0; gen_step pulses at t'+4, t'+8, t'+12 (t' = setup_sync fall); direction and toggle presses ignored.
- Run mode, reset asserted one cycle before counter wrap -> no gen_step; next gen_step exactly 4 cycles after reset deasserts (setup still 0 after synchroniser latency).
